wb_timeout: RTL and testbench

WB_TIMEOUT -- requirements
Module: wb_timeout

---
 rtl/wb_timeout_pkg.sv | 20 ++
 rtl/wb_timeout.sv | 128 ++++++++++++
 tb/tb_wb_timeout.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_timeout_pkg.sv
// rtl/wb_timeout_pkg.sv - shared wb_intercon helpers: clog2 with a fallback for tools lacking $clog2
package wb_timeout_pkg;

    function automatic int clog2(input int value);
`ifdef BROKEN_CLOG2
        int res;
        int v;
        res = 0;
        v = value - 1;
        while (v > 0) begin
            res = res + 1;
            v = v >> 1;
        end
        return res;
`else
        return $clog2(value);
`endif
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// rtl/wb_timeout.sv - aborts an unanswered wishbone strobe with err after a fixed cycle budget
module wb_timeout #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int timeout = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [dw-1:0] wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [dw-1:0] wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [dw-1:0] wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [dw-1:0] wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i,
    output logic          tmo_o,
    output logic [aw-1:0] tmo_adr_o
);
    import wb_timeout_pkg::*;

    localparam int cw = clog2(timeout + 1);
    localparam logic [cw-1:0] cnt_last = cw'(timeout - 1);

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        ERR   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [cw-1:0] cnt;
    logic [cw-1:0] cnt_nxt;
    logic          busy;
    logic          resp;

    assign busy = wbm_cyc_i & wbm_stb_i;
    assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_sel_o = wbm_sel_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_cti_o = wbm_cti_i;
    assign wbs_bte_o = wbm_bte_i;
    assign wbm_dat_o = wbs_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= PASS;
            cnt       <= '0;
            tmo_adr_o <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ERR) begin
                tmo_adr_o <= wbm_adr_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbm_rty_o = 1'b0;
        tmo_o     = 1'b0;
        case (state)
            PASS: begin
                wbs_cyc_o = wbm_cyc_i;
                wbs_stb_o = wbm_stb_i;
                wbm_ack_o = wbs_ack_i;
                wbm_err_o = wbs_err_i;
                wbm_rty_o = wbs_rty_i;
                // the window restarts on every response, so each burst beat is timed alone
                if (busy && !resp) begin
                    if (cnt == cnt_last) begin
                        state_nxt = ERR;
                    end else begin
                        cnt_nxt = cnt + cw'(1);
                    end
                end
            end
            ERR: begin
                wbm_err_o = 1'b1;
                tmo_o     = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!wbm_cyc_i) begin
                    state_nxt = PASS;
                end
            end
            default: begin
                state_nxt = PASS;
            end
        endcase
        if (wb_rst_i) begin
            wbs_cyc_o = 1'b0;
            wbs_stb_o = 1'b0;
            wbm_ack_o = 1'b0;
            wbm_err_o = 1'b0;
            wbm_rty_o = 1'b0;
            tmo_o     = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_timeout.sv
// tb/tb_wb_timeout.sv - scoreboard bench for wb_timeout with a cycle-budget reference model
module tb_wb_timeout;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_adr = '0, m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
    logic [2:0]  m_cti = '0;
    logic [1:0]  m_bte = '0;
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, tmo_adr_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, tmo_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;

    wb_timeout #(.dw(32), .aw(32), .timeout(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .tmo_o(tmo_o), .tmo_adr_o(tmo_adr_o)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        bit          chk_dat;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [31:0] adr;
    } tmo_t;

    rsp_t rsp_q[$];
    tmo_t tmo_q[$];
    int   cyc_n = 0;
    int   vecs = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [2:0] onehot(input int k);
        return (k == 0) ? 3'b001 : (k == 1) ? 3'b010 : 3'b100;
    endfunction

    // Model: a response in beat-cycle d < TMO passes through at d; otherwise err appears at TMO.
    task automatic beat(input logic [31:0] adr, input int d, input int k, input logic [2:0] cti,
                        input bit expect_rsp, input int rst_at);
        int          start;
        int          end_c;
        logic [31:0] rdat;
        rsp_t        e;
        tmo_t        t;
        m_adr = adr; m_cyc = 1'b1; m_stb = 1'b1; m_cti = cti;
        m_dat = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
        rdat  = $urandom;
        start = cyc_n;
        end_c = (d < TMO) ? d : TMO;
        if (expect_rsp) begin
            e.cyc = start + end_c;
            e.kind = (d < TMO) ? onehot(k) : 3'b010;
            e.chk_dat = (d < TMO);
            e.dat = rdat;
            rsp_q.push_back(e);
            if (d >= TMO) begin
                t.cyc = start + TMO;
                t.adr = adr;
                tmo_q.push_back(t);
            end
        end
        for (int c = 0; c <= end_c; c++) begin
            s_dat = (c == d) ? rdat : $urandom;
            {s_rty, s_err, s_ack} = (c == d) ? onehot(k) : 3'b000;
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            if (c == 0 && rst_at != 0) begin
                chk("pass_adr_dat", {wbs_adr_o, wbs_dat_o}, {m_adr, m_dat});
                chk("pass_ctrl", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o},
                    {m_sel, m_we, m_cti, m_bte, 2'b11});
            end
            if (c == rst_at) begin
                chk("rst_err_rsp", {wbm_ack_o, wbm_err_o, wbm_rty_o, tmo_o}, 4'b0000);
                chk("rst_err_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
            end
            @(posedge clk); #1;
        end
        {s_rty, s_err, s_ack} = 3'b000;
        m_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        m_cyc = 1'b0; m_stb = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every response and timeout pulse must match the head of its queue.
    initial begin
        rsp_t        e;
        tmo_t        t;
        bit          pend = 1'b0;
        logic [31:0] pend_adr = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("tmo_adr", tmo_adr_o, pend_adr);
                pend = 1'b0;
            end
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {wbm_rty_o, wbm_err_o, wbm_ack_o}, 3'b000);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", cyc_n, e.cyc);
                    chk("rsp_kind", {wbm_rty_o, wbm_err_o, wbm_ack_o}, e.kind);
                    if (e.chk_dat) chk("rsp_dat", wbm_dat_o, e.dat);
                end
            end
            if (tmo_o) begin
                if (tmo_q.size() == 0) begin
                    chk("unexpected_tmo", tmo_o, 1'b0);
                end else begin
                    t = tmo_q.pop_front();
                    chk("tmo_cycle", cyc_n, t.cyc);
                    chk("tmo_cyc_low", {wbs_cyc_o, wbs_stb_o}, 2'b00);
                    pend = 1'b1;
                    pend_adr = t.adr;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        int k;
        // reset: outputs forced low even with a live request and slave ack
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rsp", {wbm_ack_o, wbm_err_o, wbm_rty_o, tmo_o}, 4'b0000);
        chk("reset_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        chk("post_reset_tmo", {tmo_o, tmo_adr_o}, 33'd0);
        chk("post_reset_cnt", 64'(dut.cnt), 64'd0);
        @(posedge clk); #1;

        // normal access acked after 3 cycles
        beat(32'h0000_0100, 3, 0, 3'b000, 1'b1, -1);
        idle(1);
        @(negedge clk);
        chk("cnt_cleared", 64'(dut.cnt), 64'd0);
        @(posedge clk); #1;

        // dead slave
        beat(32'h1000_0040, 1000, 0, 3'b000, 1'b1, -1);
        idle(2);

        // boundaries: answer at TMO-1 passes, answer at TMO is masked by err
        beat(32'h0000_0200, TMO - 1, 0, 3'b000, 1'b1, -1);
        idle(1);
        beat(32'h0000_0300, TMO, 0, 3'b000, 1'b1, -1);
        idle(2);

        // 4-beat incrementing burst, each beat answered after 10 cycles
        for (int b = 0; b < 4; b++) begin
            beat(32'h0000_4000 + 32'(b * 4), 10, 0, (b == 3) ? 3'b111 : 3'b010, 1'b1, -1);
        end
        idle(1);

        // drain: master holds cyc and re-raises stb after err
        beat(32'h2000_0080, 1000, 0, 3'b000, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            m_cyc = 1'b1; m_stb = (i >= 1); s_ack = 1'b1; s_rty = (i == 2);
            @(negedge clk);
            chk("drain_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b00);
            chk("drain_rsp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
            @(posedge clk); #1;
        end
        s_ack = 1'b0; s_rty = 1'b0;
        idle(1);
        beat(32'h0000_0500, 2, 0, 3'b000, 1'b1, -1);
        idle(1);

        // randomized accesses, including slave err/rty and timeouts
        for (int i = 0; i < 14; i++) begin
            d = $urandom_range(0, TMO + 3);
            k = $urandom_range(0, 2);
            beat($urandom, d, k, 3'($urandom_range(0, 7)), 1'b1, -1);
            idle(2);
        end

        // reset asserted in the ERR cycle aborts the timeout
        beat(32'h3000_0000, 1000, 0, 3'b000, 1'b0, TMO);
        m_cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_err_adr", tmo_adr_o, 32'd0);
        chk("rst_mid_err_cnt", 64'(dut.cnt), 64'd0);
        @(posedge clk); #1;
        beat(32'h0000_0600, 4, 2, 3'b000, 1'b1, -1);
        idle(4);

        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("tmo_q_empty", 64'(tmo_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
